// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: PC owner, credit-limited in-order imem requester and QDEPTH-entry decode queue.
// Optional feature macro FETCH_BYPASS_EN: forward a response straight to the decoder when the queue is empty.
module rv_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_inst,
    input  logic            dec_ready
);
    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_q_pc   [QDEPTH];
    logic [XLEN-1:0] r_q_inst [QDEPTH];
    logic [XLEN-1:0] r_rq_pc  [QDEPTH];
    logic [AW-1:0]   r_rd_ptr, r_wr_ptr, r_rq_rd, r_rq_wr;
    logic [CW-1:0]   r_count, r_outstanding, r_drop_cnt;

    logic [CW:0]     w_inflight;
    logic            w_accept, w_drop, w_bypass, w_head_valid, w_wr_q, w_pop_q;
    logic [XLEN-1:0] w_rsp_pc;
    logic            w_unused_redirect_lsbs;

    assign w_unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    // Requests already accepted reserve a queue slot, so the queue can never overflow.
    assign w_inflight     = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !RST && !redirect_valid && (w_inflight < QDEPTH_W);
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_rsp_pc     = r_rq_pc[r_rq_rd];
    assign w_drop       = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_head_valid = (r_count != '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = imem_rsp_valid && !w_head_valid && (r_drop_cnt == '0) && !redirect_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign dec_valid = !redirect_valid && (w_head_valid || w_bypass);
    assign dec_pc    = w_bypass ? w_rsp_pc      : (w_head_valid ? r_q_pc[r_rd_ptr]   : '0);
    assign dec_inst  = w_bypass ? imem_rsp_data : (w_head_valid ? r_q_inst[r_rd_ptr] : '0);

    // A bypassed response that the decoder takes this cycle never occupies a slot.
    assign w_wr_q  = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0) && !(w_bypass && dec_ready);
    assign w_pop_q = dec_valid && dec_ready && !w_bypass;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_pc    <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_rq_rd       <= '0;
            r_rq_wr       <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_accept)       r_rq_wr <= r_rq_wr + AW'(1);
            if (imem_rsp_valid) r_rq_rd <= r_rq_rd + AW'(1);
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);

            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                // Only responses still to arrive after this cycle are stale.
                r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_wr_q)   r_wr_ptr   <= r_wr_ptr + AW'(1);
                if (w_pop_q)  r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_count <= r_count + CW'(w_wr_q) - CW'(w_pop_q);
                if (w_drop)   r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    // NOTE: storage arrays are not reset; r_count and r_outstanding gate every read of them.
    always_ff @(posedge CLK) begin
        if (w_accept) r_rq_pc[r_rq_wr] <= r_fetch_pc;
        if (w_wr_q) begin
            r_q_pc[r_wr_ptr]   <= w_rsp_pc;
            r_q_inst[r_wr_ptr] <= imem_rsp_data;
        end
    end
endmodule

// File: doc/rv_fetch_queue.md
# rv_fetch_queue

Parametrised instruction-fetch front end for the rv_cpu pipeline: owns the program counter, issues in-order requests to instruction memory with a credit limit, buffers returned instructions in a QDEPTH-entry queue, and presents {pc, inst} to the decoder over a valid/ready handshake. It adds stalls, PC redirect with in-flight response squashing, and variable memory latency. These replace the free-running `pc + 4` counter and the combinational fetch path.

## Interface
Parameters:
- XLEN, 32, PC and instruction width
- RESET_PC, 32'h0, PC loaded on reset; bits [1:0] must be 0
- QDEPTH, 4, queue entries; power of two, >= 2

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch address, word aligned
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid; in order, >= 1 cycle after acceptance
- imem_rsp_data  in  XLEN  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored and forced to 0
- dec_valid  out  1  queue head valid
- dec_pc  out  XLEN  PC of head instruction
- dec_inst  out  XLEN  head instruction
- dec_ready  in  1  decoder accepts head

## Operation
- State: fetch_pc, queue (QDEPTH x {pc, inst}), rd/wr pointers, count, outstanding (in-flight accepted requests), drop_cnt, req-PC FIFO (QDEPTH entries, pc of each in-flight request).
- Reset: fetch_pc=RESET_PC; count=outstanding=drop_cnt=0; pointers 0. imem_req_valid=0, dec_valid=0, dec_pc=0, dec_inst=0 while RST is high.
- Request: imem_req_valid = !redirect_valid && (count + outstanding < QDEPTH). imem_req_addr = fetch_pc. On acceptance (valid && ready): fetch_pc += 4, modulo 2^XLEN; push fetch_pc to the req-PC FIFO; outstanding += 1.
- Response: on imem_rsp_valid, pop the req-PC FIFO and decrement outstanding. If drop_cnt > 0, discard the response and decrement drop_cnt. Otherwise write {pc, data} to the queue. The credit rule guarantees the queue is never written while full.
- Dequeue: dec_valid = count > 0 (see Configuration); pop on dec_valid && dec_ready.
- Redirect (highest priority): fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; queue flushed (count=0, pointers reset); dec_valid forced 0 that cycle, so no pop. drop_cnt <= outstanding - imem_rsp_valid, counting only responses still to arrive after this cycle. A response arriving in the redirect cycle is discarded. No request issues in the redirect cycle.
- Simultaneous response and pop with the queue full: legal. Count is unchanged.
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding count. Dropping is cumulative and correct because drop_cnt never exceeds outstanding.

## Timing
- Reset to first request: first rising CLK after RST falls issues RESET_PC, combinationally visible in that cycle.
- Request-accept to dec_valid: rsp latency + 1 cycle (queue write, then registered head). With FETCH_BYPASS_EN: rsp latency + 0 when the queue is empty.
- Redirect to first new request: 1 cycle.
- Throughput: 1 instruction/cycle sustained when memory latency + 1 <= QDEPTH.
- Mid-operation reset: all state is cleared asynchronously; responses arriving after reset are illegal (memory must also reset).

## Configuration
- FETCH_BYPASS_EN defined: when count==0, drop_cnt==0, no redirect, and imem_rsp_valid: dec_valid=1, dec_pc/dec_inst come from the response directly. If dec_ready, the entry is not written to the queue; otherwise it is written normally.
- Undefined: dec outputs are driven from the queue only. Minimum response-to-decode latency is 1 cycle.

## Test plan
- Reset release, memory latency 1, dec_ready=1: requests at 0x0, 0x4, 0x8…; decoder receives pc 0x0 with inst 0x00000013 the cycle after its response, then one instruction per cycle.
- dec_ready=0 with QDEPTH=4: exactly 4 requests accepted (count + outstanding = 4), then imem_req_valid=0 until the first pop.
- Redirect to 0x103 with 3 requests in flight: next request address 0x100; the 3 stale responses are dropped; first dec_pc=0x100.
- Redirect in the same cycle as a response and a pending dec handshake: response dropped, no pop, drop_cnt = outstanding - 1.
- PC wrap: redirect to 0xFFFFFFFC; the next two requests are 0xFFFFFFFC and 0x00000000.
- FETCH_BYPASS_EN, empty queue, response with dec_ready=1: dec_valid in the same cycle as imem_rsp_valid; count stays 0.
